// File: rtl/jt51_uart_host.sv
// rtl/jt51_uart_host.sv - host-side UART link: ROM download, command forwarding, sample deframing
//
// Purpose: drives the TX side of a uart_transceiver. A start pulse first streams a
// 2^ROM_AW-byte ROM image, one byte per tx_done. After that, single-byte sound
// commands are forwarded. On the RX side, little-endian 16-bit sample words are
// reassembled and buffered in a show-ahead FIFO.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   start                 pulse, begins a ROM download (honoured only in IDLE)
//   rom_addr/rom_data     image ROM, synchronous read with 1-cycle latency
//   prog_busy/prog_done   download in progress / download finished
//   cmd_data/valid/ready  sound command handshake (open only after prog_done)
//   tx_data/tx_wr/tx_done byte, write strobe and byte-sent pulse to/from the UART
//   rx_data/done/error    received byte, byte strobe and framing error
//   smp_data/valid/ready  FIFO head word and pop handshake
//   smp_overflow          sticky, a sample was dropped on a full FIFO
//   pair_drop             one-cycle pulse, an incomplete LSB was discarded

module jt51_uart_host #(
  parameter int ROM_AW      = 15,
  parameter int FIFO_AW     = 4,
  parameter int GAP_TIMEOUT = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              prog_busy,
  output logic              prog_done,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_error,
  output logic [15:0]       smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              smp_overflow,
  output logic              pair_drop
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  localparam logic MODE_CMD  = 1'b0;
  localparam logic MODE_PROG = 1'b1;

  localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);
  localparam int          DEPTH    = 1 << FIFO_AW;

  // ---------------------------------------------------------------- TX side
  logic [1:0] state;
  logic       mode;
  logic [7:0] cmd_hold;
  logic [7:0] tx_hold;
  logic [7:0] tx_src;

  // start has priority over a pending command in the same IDLE cycle
  assign cmd_ready = (state == IDLE) && prog_done && !start;
  assign tx_src    = (mode == MODE_PROG) ? rom_data : cmd_hold;

  // The strobe and byte are presented combinationally in SEND so the ROM byte
  // fetched during FETCH goes out without another register stage; tx_hold keeps
  // the last byte on tx_data afterwards.
  assign tx_wr   = (state == SEND);
  assign tx_data = tx_wr ? tx_src : tx_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= MODE_CMD;
      rom_addr  <= '0;
      prog_busy <= 1'b0;
      prog_done <= 1'b0;
      cmd_hold  <= 8'h00;
      tx_hold   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr  <= '0;
            prog_done <= 1'b0;
            prog_busy <= 1'b1;
            mode      <= MODE_PROG;
            state     <= FETCH;
          end else if (prog_done && cmd_valid) begin
            cmd_hold <= cmd_data;
            mode     <= MODE_CMD;
            state    <= SEND;
          end
        end
        FETCH: state <= SEND;
        SEND: begin
          tx_hold <= tx_src;
          state   <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (mode == MODE_CMD) begin
              state <= IDLE;
            end else if (&rom_addr) begin
              // last byte: the address stays parked at all-ones
              prog_busy <= 1'b0;
              prog_done <= 1'b1;
              state     <= IDLE;
            end else begin
              rom_addr <= rom_addr + ROM_AW'(1);
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX deframer
  logic        phase;
  logic [7:0]  lsb;
  logic [15:0] gap_cnt;
  logic        push;

  assign push = rx_done && !rx_error && phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      lsb       <= 8'h00;
      gap_cnt   <= 16'h0000;
      pair_drop <= 1'b0;
    end else begin
      pair_drop <= 1'b0;
      if (rx_done) begin
        if (rx_error) begin
          phase     <= 1'b0;
          pair_drop <= phase;
        end else if (!phase) begin
          lsb     <= rx_data;
          phase   <= 1'b1;
          gap_cnt <= 16'h0000;
        end else begin
          phase <= 1'b0;
        end
      end else if (phase) begin
        if (gap_cnt == GAP_LAST) begin
          phase     <= 1'b0;
          pair_drop <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + 16'h0001;
        end
      end
    end
  end

  // ---------------------------------------------------------------- sample FIFO
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [15:0]      mem [0:DEPTH-1];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign smp_valid = (wptr != rptr);
  assign full      = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                     (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign pop       = smp_valid && smp_ready;
  // a pop in the same cycle frees the slot the new word lands in
  assign push_ok   = push && (!full || pop);
  assign smp_data  = smp_valid ? mem[rptr[FIFO_AW-1:0]] : 16'h0000;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= {rx_data, lsb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      smp_overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + (FIFO_AW+1)'(1);
      if (pop)     rptr <= rptr + (FIFO_AW+1)'(1);
      if (push && !push_ok) smp_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt51_uart_host.sv
// tb/tb_jt51_uart_host.sv - self-checking bench for jt51_uart_host
module tb_jt51_uart_host;

  localparam int ROM_AW = 4;
  localparam int FIFO_AW = 4;
  localparam int GAP = 64;
  localparam int NROM = 1 << ROM_AW;
  localparam int DEPTH = 1 << FIFO_AW;

  logic              clk, rst, start;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              prog_busy, prog_done;
  logic [7:0]        cmd_data;
  logic              cmd_valid, cmd_ready;
  logic [7:0]        tx_data;
  logic              tx_wr, tx_done;
  logic [7:0]        rx_data;
  logic              rx_done, rx_error;
  logic [15:0]       smp_data;
  logic              smp_valid, smp_ready, smp_overflow, pair_drop;

  jt51_uart_host #(.ROM_AW(ROM_AW), .FIFO_AW(FIFO_AW), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .prog_busy(prog_busy), .prog_done(prog_done), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_overflow(smp_overflow), .pair_drop(pair_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous image ROM, one cycle of read latency
  logic [7:0] rom [0:NROM-1];
  logic [7:0] rom_q;
  always @(posedge clk) rom_q <= rom[rom_addr];
  assign rom_data = rom_q;

  int n_assert = 0;
  int n_fail = 0;
  bit saw_ready;

  // reference model of the RX path: pending LSB and expected FIFO contents
  logic [7:0]  pend[$];
  logic [15:0] expq[$];
  bit          ovf_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rom_addr"}, 32'(rom_addr), 0);
    chk({tag, " tx_data"}, 32'(tx_data), 0);
    chk({tag, " tx_wr"}, 32'(tx_wr), 0);
    chk({tag, " prog_busy"}, 32'(prog_busy), 0);
    chk({tag, " prog_done"}, 32'(prog_done), 0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, " smp_valid"}, 32'(smp_valid), 0);
    chk({tag, " smp_data"}, 32'(smp_data), 0);
    chk({tag, " smp_overflow"}, 32'(smp_overflow), 0);
    chk({tag, " pair_drop"}, 32'(pair_drop), 0);
  endtask

  // Called one negedge after the start cycle; the first tx_wr is due at the next negedge.
  task automatic download(input string tag);
    int  cd;
    int  idx;
    bit  last_sent;
    cd = 0; idx = 0; last_sent = 0;
    for (int cyc = 0; cyc < 2000 && !last_sent; cyc++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (cmd_ready) saw_ready = 1'b1;
      if (tx_wr) begin
        if (idx == 0) chk({tag, " first_wr_latency"}, 32'(cyc), 0);
        if (idx < NROM) chk({tag, " byte"}, 32'(tx_data), 32'(rom[idx]));
        idx++;
        cd = 50;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (idx == NROM) begin
            chk({tag, " done_before_last"}, 32'(prog_done), 0);
            cmd_valid = 1'b0;
            last_sent = 1'b1;
          end
          tx_done = 1'b1;
        end
      end
    end
    @(negedge clk);
    tx_done = 1'b0;
    chk({tag, " wr_count"}, 32'(idx), 32'(NROM));
    chk({tag, " prog_done"}, 32'(prog_done), 1);
    chk({tag, " prog_busy"}, 32'(prog_busy), 0);
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(NROM - 1));
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit err);
    bit drop_exp;
    @(negedge clk);
    rx_data = b; rx_done = 1'b1; rx_error = err;
    @(negedge clk);
    rx_done = 1'b0; rx_error = 1'b0;
    drop_exp = 1'b0;
    if (err) begin
      drop_exp = (pend.size() > 0);
      pend.delete();
    end else if (pend.size() == 0) begin
      pend.push_back(b);
    end else begin
      if (expq.size() < DEPTH) expq.push_back({b, pend[0]});
      else ovf_exp = 1'b1;
      pend.delete();
    end
    chk("rx pair_drop", 32'(pair_drop), 32'(drop_exp));
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    @(negedge clk);
    chk({tag, " smp_valid"}, 32'(smp_valid), 1);
    e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
    chk({tag, " smp_data"}, 32'(smp_data), 32'(e));
    smp_ready = 1'b1;
    @(negedge clk);
    smp_ready = 1'b0;
  endtask

  initial begin
    int drops;
    logic [7:0] c2, lsb_b, msb_b;
    rst = 1'b1; start = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b0; tx_done = 1'b0;
    rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0; smp_ready = 1'b0; ovf_exp = 1'b0;
    for (int i = 0; i < NROM; i++) rom[i] = 8'(i) ^ 8'hA5;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // commands are refused before any download
    cmd_data = 8'hEE; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_start cmd_ready", 32'(cmd_ready), 0);
    chk("pre_start tx_wr", 32'(tx_wr), 0);

    // start together with cmd_valid: download wins
    start = 1'b1;
    #1 chk("start_vs_cmd cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    start = 1'b0;
    chk("fetch prog_busy", 32'(prog_busy), 1);
    chk("fetch tx_wr", 32'(tx_wr), 0);
    saw_ready = 1'b0;
    download("dl1");
    chk("dl1 cmd_ready_during", 32'(saw_ready), 0);

    // command 3C, valid held: one acceptance, next one waits for tx_done
    cmd_data = 8'h3C; cmd_valid = 1'b1;
    #1 chk("cmd ready_idle", 32'(cmd_ready), 1);
    @(negedge clk);
    c2 = 8'($urandom);
    cmd_data = c2;
    chk("cmd tx_wr", 32'(tx_wr), 1);
    chk("cmd tx_data", 32'(tx_data), 32'h3C);
    chk("cmd ready_send", 32'(cmd_ready), 0);
    saw_ready = 1'b0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) saw_ready = 1'b1;
      if (tx_wr) drops++;
    end
    chk("cmd no_second_accept", 32'(saw_ready), 0);
    chk("cmd no_extra_wr", 32'(drops), 0);
    chk("cmd tx_data_held", 32'(tx_data), 32'h3C);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("cmd2 ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd2 tx_wr", 32'(tx_wr), 1);
    chk("cmd2 tx_data", 32'(tx_data), 32'(c2));
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;

    // RX pairs
    rx_byte(8'h34, 0);
    rx_byte(8'h12, 0);
    chk("rx first_valid", 32'(smp_valid), 1);
    rx_byte(8'hCD, 0);
    rx_byte(8'hAB, 0);
    pop_chk("rx w1234");
    pop_chk("rx wABCD");
    rx_byte(8'h77, 0);
    rx_byte(8'h88, 1);
    rx_byte(8'($urandom), 0);
    rx_byte(8'($urandom), 0);
    pop_chk("rx after_err");

    // gap timeout on a lone LSB
    rx_byte(8'h55, 0);
    drops = 0;
    for (int i = 0; i < GAP + 8; i++) begin
      @(negedge clk);
      if (pair_drop) drops++;
    end
    pend.delete();
    chk("gap drop_count", 32'(drops), 1);
    rx_byte(8'h01, 0);
    rx_byte(8'h02, 0);
    pop_chk("gap w0201");

    // random bytes with occasional framing errors
    for (int i = 0; i < 12; i++) rx_byte(8'($urandom), ($urandom_range(0, 3) == 0));
    rx_byte(8'h00, 1);
    while (expq.size() > 0) pop_chk("rand");
    @(negedge clk);
    chk("rand drained", 32'(smp_valid), 0);

    // overflow: 17 pairs with no pops
    for (int i = 0; i < DEPTH; i++) begin
      rx_byte(8'($urandom), 0);
      rx_byte(8'($urandom), 0);
    end
    chk("ovf not_yet", 32'(smp_overflow), 0);
    rx_byte(8'($urandom), 0);
    rx_byte(8'($urandom), 0);
    chk("ovf sticky", 32'(smp_overflow), 32'(ovf_exp));
    chk("ovf depth", 32'(expq.size()), 32'(DEPTH));
    // pop on the push cycle of a full FIFO: the new word is kept
    lsb_b = 8'($urandom);
    msb_b = 8'($urandom);
    rx_byte(lsb_b, 0);
    @(negedge clk);
    rx_data = msb_b; rx_done = 1'b1; smp_ready = 1'b1;
    chk("ovf pop_head", 32'(smp_data), 32'(expq[0]));
    @(negedge clk);
    rx_done = 1'b0; smp_ready = 1'b0;
    void'(expq.pop_front());
    expq.push_back({msb_b, lsb_b});
    pend.delete();
    while (expq.size() > 0) pop_chk("ovf drain");
    @(negedge clk);
    chk("ovf empty", 32'(smp_valid), 0);
    chk("ovf still_set", 32'(smp_overflow), 1);

    // reset in the middle of a download
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      tx_done = (i % 40 == 39);
    end
    tx_done = 1'b0;
    chk("mid busy", 32'(prog_busy), 1);
    rst = 1'b1;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    // fresh download of a random image
    for (int i = 0; i < NROM; i++) rom[i] = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    download("dl2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
